// File: rtl/wb_hilo_llbit_unit_pkg.sv
// Shared defines for the write-back HI/LO/LLbit unit: word constants,
// write-enable encodings, reset polarity and the register bus width.
package wb_hilo_llbit_unit_pkg;

    localparam int                   RegBusWidth  = 32;
    localparam logic [RegBusWidth-1:0] ZeroWord   = '0;
    localparam logic                 WriteEnable  = 1'b1;
    localparam logic                 WriteDisable = 1'b0;
    // Reset is active-low throughout the pipeline.
    localparam logic                 ResetEnable  = 1'b0;

endpackage

// File: rtl/wb_hilo_forward.sv
// Three-source HI/LO forwarding mux: MEM result, then WB result, then the
// architectural pair. HI and LO always come from the same source so a
// consumer never sees a torn pair. Reusable by the EX stage.
module wb_hilo_forward
    import wb_hilo_llbit_unit_pkg::*;
#(
    parameter int DATA_WIDTH = RegBusWidth
) (
    input  logic                  mem_whilo,
    input  logic [DATA_WIDTH-1:0] mem_hi,
    input  logic [DATA_WIDTH-1:0] mem_lo,
    input  logic                  wb_whilo,
    input  logic [DATA_WIDTH-1:0] wb_hi,
    input  logic [DATA_WIDTH-1:0] wb_lo,
    input  logic [DATA_WIDTH-1:0] hi,
    input  logic [DATA_WIDTH-1:0] lo,
    output logic [DATA_WIDTH-1:0] hi_fwd,
    output logic [DATA_WIDTH-1:0] lo_fwd
);

    // Youngest producer wins; fall back to the stored pair.
    always_comb begin
        hi_fwd = hi;
        lo_fwd = lo;
        if (mem_whilo == WriteEnable) begin
            hi_fwd = mem_hi;
            lo_fwd = mem_lo;
        end else if (wb_whilo == WriteEnable) begin
            hi_fwd = wb_hi;
            lo_fwd = wb_lo;
        end
    end

endmodule

// File: rtl/wb_hilo_llbit_unit.sv
// Write-back consumer of MEM/WB: holds architectural HI/LO and LLbit and
// forwards them to EX (HI/LO) and MEM (LLbit).
// Optional build macro WB_RETIRE_COUNT_EN adds HI/LO-write and
// LLbit-clear retire counters.
module wb_hilo_llbit_unit
    import wb_hilo_llbit_unit_pkg::*;
#(
    parameter int DATA_WIDTH  = RegBusWidth,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  wb_hi_input,
    input  logic [DATA_WIDTH-1:0]  wb_lo_input,
    input  logic                   wb_whilo_input,
    input  logic                   wb_LLbit_write_enable_input,
    input  logic                   wb_LLbit_input,
    input  logic [DATA_WIDTH-1:0]  mem_hi_input,
    input  logic [DATA_WIDTH-1:0]  mem_lo_input,
    input  logic                   mem_whilo_input,
    input  logic                   flush_input,
    output logic [DATA_WIDTH-1:0]  hi_output,
    output logic [DATA_WIDTH-1:0]  lo_output,
    output logic [DATA_WIDTH-1:0]  hi_forward_output,
    output logic [DATA_WIDTH-1:0]  lo_forward_output,
    output logic                   LLbit_output,
    output logic                   LLbit_stored_output
`ifdef WB_RETIRE_COUNT_EN
   ,output logic [COUNT_WIDTH-1:0] hilo_write_count_output,
    output logic [COUNT_WIDTH-1:0] llbit_clear_count_output
`endif
);

    if (COUNT_WIDTH < 1) begin : g_bad_count_width
        $error("COUNT_WIDTH must be at least 1");
    end

    logic [DATA_WIDTH-1:0] hi_q;
    logic [DATA_WIDTH-1:0] lo_q;
    logic                  llbit_q;

    // HI and LO share one enable so both update on the same edge.
    always_ff @(posedge clock or negedge reset) begin
        if (reset == ResetEnable) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (wb_whilo_input == WriteEnable) begin
            hi_q <= wb_hi_input;
            lo_q <= wb_lo_input;
        end
    end

    // LLbit: flush clears it ahead of any pending SC/LL write.
    always_ff @(posedge clock or negedge reset) begin
        if (reset == ResetEnable) begin
            llbit_q <= 1'b0;
        end else if (flush_input) begin
            llbit_q <= 1'b0;
        end else if (wb_LLbit_write_enable_input == WriteEnable) begin
            llbit_q <= wb_LLbit_input;
        end
    end

    // Forwarded LLbit for MEM mirrors the register's next-state priority.
    always_comb begin
        LLbit_output = llbit_q;
        if (flush_input)
            LLbit_output = 1'b0;
        else if (wb_LLbit_write_enable_input == WriteEnable)
            LLbit_output = wb_LLbit_input;
    end

    wb_hilo_forward #(.DATA_WIDTH(DATA_WIDTH)) u_fwd (
        .mem_whilo (mem_whilo_input),
        .mem_hi    (mem_hi_input),
        .mem_lo    (mem_lo_input),
        .wb_whilo  (wb_whilo_input),
        .wb_hi     (wb_hi_input),
        .wb_lo     (wb_lo_input),
        .hi        (hi_q),
        .lo        (lo_q),
        .hi_fwd    (hi_forward_output),
        .lo_fwd    (lo_forward_output)
    );

    assign hi_output           = hi_q;
    assign lo_output           = lo_q;
    assign LLbit_stored_output = llbit_q;

`ifdef WB_RETIRE_COUNT_EN
    logic [COUNT_WIDTH-1:0] hilo_cnt_q;
    logic [COUNT_WIDTH-1:0] clr_cnt_q;

    // Retire counters; both wrap naturally at their width.
    always_ff @(posedge clock or negedge reset) begin
        if (reset == ResetEnable) begin
            hilo_cnt_q <= '0;
            clr_cnt_q  <= '0;
        end else begin
            if (wb_whilo_input == WriteEnable)
                hilo_cnt_q <= hilo_cnt_q + 1'b1;
            if (flush_input && llbit_q)
                clr_cnt_q <= clr_cnt_q + 1'b1;
        end
    end

    assign hilo_write_count_output  = hilo_cnt_q;
    assign llbit_clear_count_output = clr_cnt_q;
`endif

endmodule

// File: tb/tb_wb_hilo_llbit_unit.sv
// Self-checking bench for wb_hilo_llbit_unit: directed cases then random
// traffic, compared against a behavioural model of the architectural state.
module tb_wb_hilo_llbit_unit;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] wb_hi, wb_lo, mem_hi, mem_lo;
    logic          wb_whilo, wb_llwe, wb_ll, mem_whilo, flush;
    logic [DW-1:0] hi_o, lo_o, hi_f, lo_f;
    logic          ll_o, ll_s;
`ifdef WB_RETIRE_COUNT_EN
    logic [CW-1:0] hilo_cnt, clr_cnt;
`endif

    wb_hilo_llbit_unit #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clock                       (clock),
        .reset                       (reset),
        .wb_hi_input                 (wb_hi),
        .wb_lo_input                 (wb_lo),
        .wb_whilo_input              (wb_whilo),
        .wb_LLbit_write_enable_input (wb_llwe),
        .wb_LLbit_input              (wb_ll),
        .mem_hi_input                (mem_hi),
        .mem_lo_input                (mem_lo),
        .mem_whilo_input             (mem_whilo),
        .flush_input                 (flush),
        .hi_output                   (hi_o),
        .lo_output                   (lo_o),
        .hi_forward_output           (hi_f),
        .lo_forward_output           (lo_f),
        .LLbit_output                (ll_o),
        .LLbit_stored_output         (ll_s)
`ifdef WB_RETIRE_COUNT_EN
       ,.hilo_write_count_output     (hilo_cnt),
        .llbit_clear_count_output    (clr_cnt)
`endif
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Architectural model state.
    logic [DW-1:0] m_hi = '0, m_lo = '0;
    logic          m_ll = 1'b0;
    logic [CW-1:0] m_hcnt = '0, m_ccnt = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_stored();
        chk("hi_stored", 64'(hi_o), 64'(m_hi));
        chk("lo_stored", 64'(lo_o), 64'(m_lo));
        chk("ll_stored", 64'(ll_s), 64'(m_ll));
`ifdef WB_RETIRE_COUNT_EN
        chk("hilo_cnt", 64'(hilo_cnt), 64'(m_hcnt));
        chk("clr_cnt",  64'(clr_cnt),  64'(m_ccnt));
`endif
    endtask

    // Forwarded values as the architecture sees them right now.
    task automatic chk_fwd();
        logic [DW-1:0] eh, el;
        logic          ell;
        eh  = mem_whilo ? mem_hi : (wb_whilo ? wb_hi : m_hi);
        el  = mem_whilo ? mem_lo : (wb_whilo ? wb_lo : m_lo);
        ell = flush ? 1'b0 : (wb_llwe ? wb_ll : m_ll);
        chk("hi_fwd", 64'(hi_f), 64'(eh));
        chk("lo_fwd", 64'(lo_f), 64'(el));
        chk("ll_fwd", 64'(ll_o), 64'(ell));
    endtask

    // Drive one cycle, check comb outputs mid-cycle and state after the edge.
    task automatic cyc(input logic [DW-1:0] mh, input logic [DW-1:0] ml, input logic mw,
                       input logic [DW-1:0] wh, input logic [DW-1:0] wl, input logic ww,
                       input logic lwe, input logic lv, input logic fl);
        mem_hi = mh; mem_lo = ml; mem_whilo = mw;
        wb_hi = wh;  wb_lo = wl;  wb_whilo = ww;
        wb_llwe = lwe; wb_ll = lv; flush = fl;
        @(negedge clock);
        chk_fwd();
        chk_stored();
        @(posedge clock);
        if (ww) begin m_hi = wh; m_lo = wl; m_hcnt = m_hcnt + 1'b1; end
        if (fl) begin
            if (m_ll) m_ccnt = m_ccnt + 1'b1;
            m_ll = 1'b0;
        end else if (lwe) begin
            m_ll = lv;
        end
        #1;
        chk_stored();
    endtask

    task automatic idle();
        cyc('0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        mem_hi = '0; mem_lo = '0; mem_whilo = 1'b0;
        wb_hi = '0; wb_lo = '0; wb_whilo = 1'b0;
        wb_llwe = 1'b0; wb_ll = 1'b0; flush = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk_stored();
        chk_fwd();
        @(posedge clock);
        #1 reset = 1'b1;

        // Plain WB write, forward visible same cycle.
        cyc('0, '0, 1'b0, 32'h11, 32'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("hi_after_wr", 64'(hi_o), 64'h11);
        // MEM forward beats WB; registers take WB.
        cyc(32'hAAAA0000, 32'h0000BBBB, 1'b1, 32'h1, 32'h2, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lo_after_mem_wb", 64'(lo_o), 64'h2);
        // LLbit set, then flush clears it.
        cyc('0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("ll_set", 64'(ll_s), 64'h1);
        cyc('0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ll_flushed", 64'(ll_s), 64'h0);
        // Flush beats a simultaneous LLbit write.
        cyc('0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("ll_flush_wins", 64'(ll_s), 64'h0);

`ifdef WB_RETIRE_COUNT_EN
        // Counter wrap: 17 writes since reset total with the 2 above -> 15 more.
        for (int i = 0; i < 15; i++)
            cyc('0, '0, 1'b0, 32'(i), 32'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("hilo_wrap", 64'(hilo_cnt), 64'h1);
        for (int i = 0; i < 2; i++) begin
            cyc('0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
            cyc('0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("clr_three", 64'(clr_cnt), 64'h3);
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom, $urandom, ($urandom_range(0, 3) == 0),
                $urandom, $urandom, ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1,
                ($urandom_range(0, 5) == 0));
        end

        // Mid-cycle reset with a populated pair and LLbit set.
        cyc('0, '0, 1'b0, 32'hDEADBEEF, 32'h12345678, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("hi_before_rst", 64'(hi_o), 64'hDEADBEEF);
        mem_whilo = 1'b0; wb_whilo = 1'b0; wb_llwe = 1'b0; flush = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        m_hi = '0; m_lo = '0; m_ll = 1'b0; m_hcnt = '0; m_ccnt = '0;
        #1;
        chk_stored();
        chk_fwd();
        @(posedge clock);
        #1 reset = 1'b1;
        idle();
        cyc('0, '0, 1'b0, 32'h5, 32'h6, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
